// File: rtl/move_scheduler.sv
// move_scheduler: latches move commands and gravity, arbitrates them onto a valid/ready/done
// datapath, runs hard drop and requests lock. Define LOCK_DELAY_EN to enable the lock-delay state.
module move_scheduler #(
    parameter int GRAV_W      = 6,
    parameter int DROP_W      = 5,
    parameter int LOCK_FRAMES = 30,
    parameter int LOCK_RESETS = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_game,
    input  logic              enable,
    input  logic [GRAV_W-1:0] gravity_period,
    input  logic              cmd_left,
    input  logic              cmd_right,
    input  logic              cmd_down,
    input  logic              cmd_rotate,
    input  logic              cmd_drop,
    output logic              mv_valid,
    output logic [1:0]        mv_op,
    input  logic              mv_ready,
    input  logic              mv_done,
    input  logic              mv_ok,
    output logic              lock_req,
    input  logic              lock_ack,
    output logic [DROP_W-1:0] drop_rows,
    output logic              busy
);
    localparam logic [1:0] OP_LEFT  = 2'd0;
    localparam logic [1:0] OP_RIGHT = 2'd1;
    localparam logic [1:0] OP_DOWN  = 2'd2;
    localparam logic [1:0] OP_ROT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_HDROP, S_HWAIT, S_LOCK, S_LDELAY
    } state_t;

    state_t            r_state;
    logic              r_mv_valid;
    logic [1:0]        r_mv_op;
    logic              r_lock_req;
    logic [DROP_W-1:0] r_drop_rows;
    logic              r_busy;
    logic              r_p_left, r_p_right, r_p_down, r_p_rot, r_p_drop, r_p_grav;
    logic [GRAV_W-1:0] r_grav_cnt;

    logic              w_arb_state, w_in_hdrop, w_issue_xfer, w_down_xfer;
    logic              w_hdrop_entry, w_lock_clr, w_clr_all, w_cmd_en;
    logic              w_lr_conflict, w_any, w_grav_hit, w_ldly_expired;
    logic [1:0]        w_arb_op;
    logic [GRAV_W-1:0] w_period;
    logic [GRAV_W:0]   w_cnt_inc;

`ifdef LOCK_DELAY_EN
    localparam int TMR_W = $clog2(LOCK_FRAMES + 1);
    localparam int RST_W = $clog2(LOCK_RESETS + 1);
    logic             r_in_ldly;
    logic [TMR_W-1:0] r_ldly_tmr;
    logic [RST_W-1:0] r_ldly_rst;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (LOCK_FRAMES != 0) ^ (LOCK_RESETS != 0);
`endif

    always_comb begin
        w_arb_state   = (r_state == S_IDLE) || (r_state == S_LDELAY);
        w_in_hdrop    = (r_state == S_HDROP) || (r_state == S_HWAIT);
        w_issue_xfer  = (r_state == S_ISSUE) && mv_ready;
        w_down_xfer   = w_issue_xfer && (r_mv_op == OP_DOWN);
`ifdef LOCK_DELAY_EN
        w_ldly_expired = (r_state == S_LDELAY) && (r_ldly_tmr == '0);
`else
        w_ldly_expired = 1'b0;
`endif
        w_hdrop_entry = w_arb_state && enable && r_p_drop && !w_ldly_expired;
        w_lock_clr    = (r_state == S_LOCK) && lock_ack;
        w_clr_all     = !enable || w_hdrop_entry || w_lock_clr;
        w_cmd_en      = enable && !w_in_hdrop;
        w_lr_conflict = r_p_left && r_p_right;
        w_period      = (gravity_period == '0) ? GRAV_W'(1) : gravity_period;
        w_cnt_inc     = {1'b0, r_grav_cnt} + (GRAV_W + 1)'(1);
        w_grav_hit    = tick_game && enable && (w_cnt_inc >= {1'b0, w_period});
        // Fixed priority; simultaneous LEFT and RIGHT cancel each other
        w_any    = 1'b1;
        w_arb_op = OP_DOWN;
        if (r_p_drop)                    w_arb_op = OP_DOWN;
        else if (r_p_rot)                w_arb_op = OP_ROT;
        else if (r_p_left && !r_p_right) w_arb_op = OP_LEFT;
        else if (r_p_right && !r_p_left) w_arb_op = OP_RIGHT;
        else if (r_p_down || r_p_grav)   w_arb_op = OP_DOWN;
        else                             w_any    = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p_left   <= 1'b0;
            r_p_right  <= 1'b0;
            r_p_down   <= 1'b0;
            r_p_rot    <= 1'b0;
            r_p_drop   <= 1'b0;
            r_p_grav   <= 1'b0;
            r_grav_cnt <= '0;
        end else begin
            r_p_left  <= (cmd_left && w_cmd_en) ||
                         (r_p_left && !(w_clr_all || w_lr_conflict || (w_issue_xfer && r_mv_op == OP_LEFT)));
            r_p_right <= (cmd_right && w_cmd_en) ||
                         (r_p_right && !(w_clr_all || w_lr_conflict || (w_issue_xfer && r_mv_op == OP_RIGHT)));
            r_p_rot   <= (cmd_rotate && w_cmd_en) ||
                         (r_p_rot && !(w_clr_all || (w_issue_xfer && r_mv_op == OP_ROT)));
            r_p_down  <= (cmd_down && w_cmd_en) || (r_p_down && !(w_clr_all || w_down_xfer));
            r_p_grav  <= (w_grav_hit && !w_in_hdrop) || (r_p_grav && !(w_clr_all || w_down_xfer));
            r_p_drop  <= (cmd_drop && w_cmd_en) || (r_p_drop && !w_clr_all);
            if (w_lock_clr || (w_down_xfer && r_p_down))
                r_grav_cnt <= '0;
            else if (tick_game && enable)
                r_grav_cnt <= w_grav_hit ? '0 : w_cnt_inc[GRAV_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mv_valid  <= 1'b0;
            r_mv_op     <= OP_LEFT;
            r_lock_req  <= 1'b0;
            r_drop_rows <= '0;
            r_busy      <= 1'b0;
`ifdef LOCK_DELAY_EN
            r_in_ldly   <= 1'b0;
            r_ldly_tmr  <= '0;
            r_ldly_rst  <= '0;
`endif
        end else begin
`ifdef LOCK_DELAY_EN
            if (r_in_ldly && tick_game && enable && r_ldly_tmr != '0)
                r_ldly_tmr <= r_ldly_tmr - TMR_W'(1);
`endif
            case (r_state)
                S_IDLE, S_LDELAY: begin
                    if (w_ldly_expired) begin
                        r_state    <= S_LOCK;
                        r_lock_req <= 1'b1;
                    end else if (w_hdrop_entry) begin
                        r_state     <= S_HDROP;
                        r_mv_valid  <= 1'b1;
                        r_mv_op     <= OP_DOWN;
                        r_drop_rows <= '0;
                        r_busy      <= 1'b1;
                    end else if (enable && w_any) begin
                        r_state    <= S_ISSUE;
                        r_mv_valid <= 1'b1;
                        r_mv_op    <= w_arb_op;
                        r_busy     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (mv_ready) begin
                        r_state    <= S_WAIT;
                        r_mv_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mv_done) begin
                        if (r_mv_op == OP_DOWN && !mv_ok) begin
`ifdef LOCK_DELAY_EN
                            r_state <= S_LDELAY;
                            if (!r_in_ldly) begin
                                r_in_ldly  <= 1'b1;
                                r_ldly_tmr <= TMR_W'(LOCK_FRAMES);
                            end
`else
                            r_state    <= S_LOCK;
                            r_lock_req <= 1'b1;
`endif
                        end else begin
`ifdef LOCK_DELAY_EN
                            if (r_in_ldly && r_mv_op != OP_DOWN) begin
                                r_state <= S_LDELAY;
                                if (mv_ok && r_ldly_rst != RST_W'(LOCK_RESETS)) begin
                                    r_ldly_tmr <= TMR_W'(LOCK_FRAMES);
                                    r_ldly_rst <= r_ldly_rst + RST_W'(1);
                                end
                            end else begin
                                r_in_ldly <= 1'b0;
                                r_state   <= S_IDLE;
                                r_busy    <= 1'b0;
                            end
`else
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
`endif
                        end
                    end
                end
                S_HDROP: begin
                    if (mv_ready) begin
                        r_state    <= S_HWAIT;
                        r_mv_valid <= 1'b0;
                    end
                end
                S_HWAIT: begin
                    if (mv_done) begin
                        if (mv_ok) begin
                            if (r_drop_rows != '1)
                                r_drop_rows <= r_drop_rows + DROP_W'(1);
`ifdef LOCK_DELAY_EN
                            r_in_ldly <= 1'b0;
`endif
                            // A pause ends the drop after the op in flight
                            if (enable) begin
                                r_state    <= S_HDROP;
                                r_mv_valid <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_state    <= S_LOCK;
                            r_lock_req <= 1'b1;
                        end
                    end
                end
                S_LOCK: begin
                    if (lock_ack) begin
                        r_state    <= S_IDLE;
                        r_lock_req <= 1'b0;
                        r_busy     <= 1'b0;
`ifdef LOCK_DELAY_EN
                        r_in_ldly  <= 1'b0;
                        r_ldly_tmr <= '0;
                        r_ldly_rst <= '0;
`endif
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_mv_valid <= 1'b0;
                    r_lock_req <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign mv_valid  = r_mv_valid;
    assign mv_op     = r_mv_op;
    assign lock_req  = r_lock_req;
    assign drop_rows = r_drop_rows;
    assign busy      = r_busy;
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed and randomized bench for move_scheduler with a transaction-level model.
module tb_move_scheduler;
    logic       clk = 1'b0;
    logic       rst_n, tick_game, enable;
    logic [5:0] gravity_period;
    logic       cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop;
    logic       mv_valid, mv_ready, mv_done, mv_ok;
    logic [1:0] mv_op;
    logic       lock_req, lock_ack, busy;
    logic [4:0] drop_rows;

    int         checks = 0;
    int         failures = 0;
    int         xfers = 0;
    logic [1:0] op_log[$];
    bit         ok_q[$];

    move_scheduler dut (
        .clk(clk), .rst_n(rst_n), .tick_game(tick_game), .enable(enable),
        .gravity_period(gravity_period),
        .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_down(cmd_down),
        .cmd_rotate(cmd_rotate), .cmd_drop(cmd_drop),
        .mv_valid(mv_valid), .mv_op(mv_op), .mv_ready(mv_ready),
        .mv_done(mv_done), .mv_ok(mv_ok),
        .lock_req(lock_req), .lock_ack(lock_ack), .drop_rows(drop_rows), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: log any transfer, clear one-shot pulses, answer a transfer with mv_done next cycle
    task automatic cyc();
        bit         xf;
        logic [1:0] op;
        xf = (mv_valid === 1'b1) && (mv_ready === 1'b1);
        op = mv_op;
        @(posedge clk);
        #1;
        tick_game = 0; cmd_left = 0; cmd_right = 0; cmd_down = 0; cmd_rotate = 0; cmd_drop = 0;
        lock_ack = 0; mv_done = 0; mv_ok = 0;
        if (xf) begin
            xfers++;
            op_log.push_back(op);
            mv_done = 1;
            mv_ok = (ok_q.size() > 0) ? ok_q.pop_front() : 1'b1;
        end
    endtask

    task automatic do_reset();
        ok_q.delete();
        rst_n = 0; cyc();
        rst_n = 1; cyc();
    endtask

    task automatic grav_run(input logic [5:0] p, input int nticks);
        int base, blog, eff;
        gravity_period = p;
        do_reset();
        base = xfers; blog = op_log.size();
        eff = (p == 0) ? 1 : int'(p);
        for (int k = 1; k <= nticks; k++) begin
            tick_game = 1; cyc();
            repeat (5) cyc();
            chk($sformatf("grav_p%0d_tick%0d", p, k), xfers - base, k / eff);
        end
        for (int i = blog; i < op_log.size(); i++)
            chk($sformatf("grav_p%0d_op%0d", p, i - blog), 32'(op_log[i]), 2);
    endtask

    // Model: commands pulsed together issue as ROT, then the lone LEFT/RIGHT, then DOWN
    task automatic run_cmds(input bit l, input bit r, input bit rt, input bit d, input bit down_ok,
                            input string nm);
        logic [1:0] exp_q[$];
        int         base, blog;
        bit         exp_lock;
        if (rt) exp_q.push_back(2'd3);
        if (l && !r) exp_q.push_back(2'd0);
        if (r && !l) exp_q.push_back(2'd1);
        if (d) exp_q.push_back(2'd2);
        ok_q.delete();
        foreach (exp_q[i]) ok_q.push_back((exp_q[i] == 2'd2) ? down_ok : ($urandom_range(0, 1) == 1));
        exp_lock = d && !down_ok;
        base = xfers; blog = op_log.size();
        cmd_left = l; cmd_right = r; cmd_rotate = rt; cmd_down = d;
        cyc();
        repeat (20) cyc();
        chk({nm, "_count"}, xfers - base, exp_q.size());
        foreach (exp_q[i])
            chk($sformatf("%s_op%0d", nm, i),
                (blog + i < op_log.size()) ? 32'(op_log[blog + i]) : 32'hFFFF, 32'(exp_q[i]));
        chk({nm, "_lock"}, lock_req, exp_lock);
        if (lock_req) begin lock_ack = 1; cyc(); end
        cyc();
        chk({nm, "_busy"}, busy, 0);
    endtask

    task automatic drop_run(input int k, input string nm);
        int base, blog, ndown, exp_rows;
        ok_q.delete();
        for (int i = 0; i < k; i++) ok_q.push_back(1'b1);
        ok_q.push_back(1'b0);
        exp_rows = (k > 31) ? 31 : k;
        base = xfers; blog = op_log.size();
        cmd_drop = 1; cyc();
        for (int i = 0; i < 2 * k + 20 && lock_req !== 1'b1; i++) cyc();
        chk({nm, "_lock"}, lock_req, 1);
        chk({nm, "_ops"}, xfers - base, k + 1);
        ndown = 0;
        for (int i = blog; i < op_log.size(); i++) if (op_log[i] == 2'd2) ndown++;
        chk({nm, "_downs"}, ndown, k + 1);
        chk({nm, "_rows"}, drop_rows, exp_rows);
        repeat (3) cyc();
        chk({nm, "_lock_held"}, lock_req, 1);
        chk({nm, "_rows_held"}, drop_rows, exp_rows);
        lock_ack = 1; cyc();
        chk({nm, "_unlock"}, lock_req, 0);
        chk({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        int base, n;
        rst_n = 0; tick_game = 0; enable = 1; gravity_period = 6'd63;
        cmd_left = 0; cmd_right = 0; cmd_down = 0; cmd_rotate = 0; cmd_drop = 0;
        mv_ready = 1; mv_done = 0; mv_ok = 0; lock_ack = 0;
        #1;
        cyc(); cyc();
        chk("rst_valid", mv_valid, 0);
        chk("rst_op", mv_op, 0);
        chk("rst_lock", lock_req, 0);
        chk("rst_rows", drop_rows, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1; cyc();

        grav_run(6'd3, 9);
        grav_run(6'd0, 3);
        grav_run(6'($urandom_range(1, 4)), 8);
        gravity_period = 6'd63;
        do_reset();

        run_cmds(1, 0, 1, 0, 1, "rot_left");
        run_cmds(1, 1, 0, 0, 1, "left_right");
        run_cmds(0, 0, 0, 1, 1, "down_after_lr");
        run_cmds(0, 0, 0, 1, 0, "down_fail");
        for (int it = 0; it < 8; it++)
            run_cmds($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), $sformatf("rnd%0d", it));

        base = xfers;
        cmd_left = 1; cmd_right = 1; cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("lr_busy%0d", i), busy, 0);
        end
        chk("lr_no_xfer", xfers - base, 0);

        mv_ready = 0; cmd_rotate = 1; cyc();
        for (int i = 0; i < 10 && mv_valid !== 1'b1; i++) cyc();
        base = xfers;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_valid%0d", i), mv_valid, 1);
            chk($sformatf("stall_op%0d", i), mv_op, 3);
            cyc();
        end
        mv_ready = 1; cyc();
        chk("stall_first_xfer", xfers - base, 1);
        repeat (5) cyc();
        chk("stall_single_xfer", xfers - base, 1);

        drop_run(4, "drop4");
        drop_run(int'($urandom_range(0, 6)), "drop_rnd");
        drop_run(33, "drop_sat");

        base = xfers;
        enable = 0; cmd_rotate = 1; cyc();
        repeat (5) cyc();
        chk("pause_ignore", xfers - base, 0);
        enable = 1; repeat (4) cyc();
        chk("pause_no_latch", xfers - base, 0);

        ok_q.delete();
        for (int i = 0; i < 20; i++) ok_q.push_back(1'b1);
        cmd_drop = 1; cyc();
        repeat (6) cyc();
        rst_n = 0; cyc();
        chk("hdrop_rst_valid", mv_valid, 0);
        chk("hdrop_rst_lock", lock_req, 0);
        chk("hdrop_rst_rows", drop_rows, 0);
        chk("hdrop_rst_busy", busy, 0);
        rst_n = 1; ok_q.delete(); cyc();
        n = xfers;
        mv_done = 1; mv_ok = 0; cyc();
        repeat (3) cyc();
        chk("late_done_lock", lock_req, 0);
        chk("late_done_busy", busy, 0);
        chk("late_done_valid", mv_valid, 0);
        chk("late_done_no_xfer", xfers - n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
Sequences piece-movement requests into the board collision/commit datapath, one operation at a time.
- Latches one-shot commands from input_manager (cmd_*) and an internal gravity timer driven by tick_game.
- Arbitrates the pending requests by fixed priority and issues them over a valid/ready plus done handshake.
- Runs the hard-drop loop and raises a lock request when the piece can no longer fall.

Parameters:
GRAV_W, 6, width of gravity_period and of the gravity frame counter
DROP_W, 5, width of drop_rows (rows fallen in one hard drop; saturating)
LOCK_FRAMES, 30, lock-delay length in tick_game frames (used only with the optional feature)
LOCK_RESETS, 15, maximum lock-timer restarts per piece (used only with the optional feature)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  synchronous active-low reset
tick_game  in  1  one-cycle frame strobe
enable  in  1  game running; 0 = paused or game over
gravity_period  in  GRAV_W  frames per gravity step; 0 is treated as 1
cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop  in  1 each  one-cycle command pulses
mv_valid  out  1  operation offered to the datapath
mv_op  out  2  operation code: 0 LEFT, 1 RIGHT, 2 DOWN, 3 ROTATE
mv_ready  in  1  datapath accepts the op when mv_valid && mv_ready
mv_done  in  1  one-cycle pulse, result of the accepted op
mv_ok  in  1  sampled with mv_done; 1 = move applied, 0 = collision
lock_req  out  1  level; piece must be locked
lock_ack  in  1  one-cycle pulse; lock and new spawn complete
drop_rows  out  DROP_W  rows fallen in the last hard drop; stable while lock_req is high
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all outputs, pending flags and counters; FSM goes to IDLE.
- Pending flags
  - p_left, p_right, p_down, p_rot, p_drop, p_grav: each is set on its source pulse and cleared when that op is accepted.
  - A set and a clear in the same cycle leaves the flag set.
  - If p_left and p_right are both set, both are cleared and neither is issued.
- Gravity
  - The frame counter increments on tick_game while enable=1.
  - When count+1 >= max(gravity_period,1): set p_grav and clear the counter.
  - Acceptance of a DOWN from p_down also clears the counter.
- Arbitration in IDLE, when enable=1, highest first: p_drop > p_rot > p_left/p_right > p_down > p_grav.
- States:
  - IDLE: if any flag is pending, go to ISSUE next cycle with mv_op registered.
  - ISSUE: mv_valid=1 and mv_op held stable until mv_ready. Transfer clears the matching flag(s) and goes to WAIT. A gravity DOWN and a p_down DOWN are merged, so both flags clear.
  - WAIT: hold until mv_done, then:
    - LEFT/RIGHT/ROTATE: go to IDLE regardless of mv_ok.
    - DOWN: mv_ok=1 goes to IDLE; mv_ok=0 goes to LOCK.
  - HDROP: issues DOWN repeatedly (ISSUE/WAIT sub-handshake).
    - Each mv_ok=1 increments drop_rows (saturating at 2^DROP_W-1).
    - The first mv_ok=0 goes to LOCK.
    - Entry clears drop_rows and all other pending flags.
    - Commands arriving during HDROP are discarded.
  - LOCK: lock_req=1 until lock_ack. On lock_ack, clear lock_req, all pending flags and the gravity counter, then go to IDLE.
- Pause (enable=0):
  - New pulses are ignored, pending flags are cleared and the gravity counter holds.
  - An op already accepted completes its WAIT and then returns to IDLE, not HDROP.
  - A hard drop in progress stops after the current op.
  - LOCK stays in LOCK until lock_ack.
- mv_done outside WAIT is ignored. lock_ack outside LOCK is ignored.
- Minimum op spacing is 3 cycles (IDLE, ISSUE, WAIT) when mv_ready=1 and mv_done arrives in the cycle after acceptance.

Optional Feature:
LOCK_DELAY_EN
- Defined:
  - A failed DOWN from p_down or p_grav goes to LDELAY instead of LOCK and starts a frame timer at LOCK_FRAMES.
  - In LDELAY, arbitration continues normally.
  - A successful LEFT/RIGHT/ROTATE restarts the timer, at most LOCK_RESETS times per piece.
  - A successful DOWN leaves LDELAY with no lock.
  - Timer expiry, or p_drop, goes to LOCK; p_drop first runs HDROP, which fails immediately.
- Undefined: every failed DOWN goes directly to LOCK. Hard drop goes to LOCK in both builds.

Test Plan:
1. gravity_period=3, enable=1, mv_ready=1, mv_done/mv_ok=1 one cycle after accept, 9 tick_game pulses -> exactly 3 DOWN ops accepted, on ticks 3, 6, 9.
2. cmd_rotate and cmd_left in the same cycle -> ROTATE issued first, LEFT issued next; 2 transfers in total.
3. cmd_left and cmd_right both pending -> no op issued, both flags cleared, busy stays 0.
4. mv_ready held low 5 cycles -> mv_valid=1 with mv_op stable all 5 cycles; a single transfer on the first ready cycle.
5. cmd_drop, datapath returns mv_ok=1 four times then 0 -> 5 DOWN ops, drop_rows=4, lock_req=1 until lock_ack, then IDLE with busy=0.
6. rst_n=0 during HDROP -> next cycle mv_valid=0, lock_req=0, drop_rows=0, busy=0; a later mv_done is ignored.
